// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage:
//               the FSM state encoding, the NOP word substituted for a
//               misaligned fetch, and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // Explicit 2-bit encoding for the fetch controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] C_NOP              = 32'h0000_0013;
  localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/if_fetch_if.sv
// ============================================================================
// Module      : if_fetch_if
// Description : Instruction-memory request/response bus between the fetch
//               stage (master) and the instruction memory (slave).
//               imem_req    : request valid
//               imem_addr   : request address
//               imem_gnt    : request accepted this cycle
//               imem_rvalid : read data valid (earliest one cycle after gnt)
//               imem_rdata  : instruction word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface : if_fetch_if

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Issues at most one outstanding
//               instruction-memory request, registers the returned word into
//               the IF/ID payload, and honours stall (ID back-pressure) and
//               flush (EX-resolved redirect, overriding stall).
// Ports       : clk         - clock, all state on rising edge
//               rst_n       - asynchronous active-low reset
//               npc         - next PC, sampled on accept or flush
//               flush       - redirect; npc holds the target this cycle
//               stall       - ID not ready; hold current instruction
//               pc          - current PC register
//               imem        - instruction-memory bus (master side)
//               if_valid    - IF/ID payload valid
//               if_pc       - PC of the held instruction
//               if_inst     - held instruction word
//               if_misalign - held entry came from a misaligned PC
// Config      : FETCH_MISALIGN_CHK_EN - when defined, a misaligned PC is not
//               fetched; a NOP flagged if_misalign is presented instead.
//               When undefined the address is forced word-aligned and
//               if_misalign stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [31:0] npc,
  input  wire logic        flush,
  input  wire logic        stall,
  output logic      [31:0] pc,
  if_fetch_if.master       imem,
  output logic             if_valid,
  output logic      [31:0] if_pc,
  output logic      [31:0] if_inst,
  output logic             if_misalign
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         kill_q;         // outstanding response belongs to a flushed PC
  logic         if_valid_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_inst_q;
  logic         if_misalign_q;

  logic         w_misalign;
  logic         w_req;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_misalign     = (pc_q[1:0] != 2'b00);
  assign imem.imem_addr = pc_q;
`else
  assign w_misalign     = 1'b0;
  assign imem.imem_addr = {pc_q[31:2], 2'b00};
`endif

  assign w_req         = (state_q == ST_FETCH) && !w_misalign;
  assign imem.imem_req = w_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_inst_q     <= 32'h0;
      if_misalign_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;

        ST_FETCH: begin
          if (flush) begin
            // An ungranted request may simply change address; a granted one
            // must have its response discarded.
            pc_q <= npc;
            if (w_req && imem.imem_gnt) begin
              state_q <= ST_WAIT;
              kill_q  <= 1'b1;
            end
          end
`ifdef FETCH_MISALIGN_CHK_EN
          else if (w_misalign) begin
            state_q       <= ST_HOLD;
            if_valid_q    <= 1'b1;
            if_misalign_q <= 1'b1;
            if_inst_q     <= C_NOP;
            if_pc_q       <= pc_q;
          end
`endif
          else if (imem.imem_gnt) begin
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (flush) begin
            pc_q <= npc;
            if (imem.imem_rvalid) begin
              state_q <= ST_FETCH;
              kill_q  <= 1'b0;
            end else begin
              kill_q  <= 1'b1;
            end
          end else if (imem.imem_rvalid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= ST_FETCH;
            end else begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_inst_q  <= imem.imem_rdata;
              state_q    <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (flush || !stall) begin
            pc_q          <= npc;
            if_valid_q    <= 1'b0;
            if_misalign_q <= 1'b0;
            state_q       <= ST_FETCH;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc          = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign if_misalign = if_misalign_q;

endmodule : if_fetch

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch. Directed scenarios followed
//               by randomized traffic against a transaction-level reference
//               model of the fetch stage and a randomized memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] npc;
  logic        flush;
  logic        stall;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .npc         (npc),
    .flush       (flush),
    .stall       (stall),
    .pc          (pc),
    .imem        (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_misalign (if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: what the fetch stage is doing, in transaction terms
  bit          m_boot;    // first cycle after reset, nothing issued yet
  bit          m_busy;    // a granted request awaits its response
  bit          m_stale;   // that response belongs to a redirected-away PC
  bit          m_valid;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_inst;

  int mem_cnt = 0;        // memory responder: cycles until rvalid (0 = idle)

  function automatic bit m_odd();
    return MIS_EN && (m_pc[1:0] != 2'b00);
  endfunction

  function automatic bit m_req();
    return !m_boot && !m_busy && !m_valid && !m_odd();
  endfunction

  task automatic model_reset();
    m_boot = 1; m_busy = 0; m_stale = 0; m_valid = 0; m_mis = 0;
    m_pc = RST_PC; m_ifpc = 32'h0; m_inst = 32'h0;
  endtask

  task automatic model_step(input bit f, input bit s, input logic [31:0] n,
                            input bit g, input bit rv, input logic [31:0] rd);
    logic [31:0] p;
    p = m_pc;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_valid) begin
      if (f || !s) begin m_pc = n; m_valid = 0; m_mis = 0; end
    end else if (m_busy) begin
      if (rv) begin
        m_busy = 0;
        if (!m_stale && !f) begin m_valid = 1; m_ifpc = p; m_inst = rd; end
        m_stale = 0;
      end else if (f) begin
        m_stale = 1;
      end
      if (f) m_pc = n;
    end else if (m_odd() && !f) begin
      m_valid = 1; m_mis = 1; m_inst = C_NOP; m_ifpc = p;
    end else begin
      if (g && !m_odd()) begin m_busy = 1; m_stale = f; end
      if (f) m_pc = n;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc", pc, m_pc);
    chk("imem_req", {31'h0, bus.imem_req}, {31'h0, m_req()});
    if (m_req()) chk("imem_addr", bus.imem_addr, MIS_EN ? m_pc : {m_pc[31:2], 2'b00});
    chk("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
    chk("if_pc", if_pc, m_ifpc);
    chk("if_inst", if_inst, m_inst);
    chk("if_misalign", {31'h0, if_misalign}, {31'h0, m_mis});
  endtask

  // One clock: drive inputs, let the edge happen, advance model, check
  task automatic cyc(input bit f, input bit s, input logic [31:0] n,
                     input bit g, input bit rv, input logic [31:0] rd);
    flush = f; stall = s; npc = n;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd;
    @(posedge clk);
    if (rst_n) model_step(f, s, n, g, rv, rd);
    #1;
    chk_all();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    repeat (cycles) cyc(0, 0, 32'h0, 0, 0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    flush = 0; stall = 0; npc = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    rst_n = 1'b0;
    model_reset();

    // Reset and first fetch: gnt immediately, data the next cycle
    do_reset(2);
    cyc(0, 0, 32'h4, 0, 0, 32'h0);                 // IDLE -> FETCH
    chk("first_addr", bus.imem_addr, RST_PC);
    cyc(0, 0, 32'h4, 1, 0, 32'h0);                 // granted
    cyc(0, 1, 32'h4, 0, 1, 32'h0050_0093);         // data returns
    chk("first_valid", {31'h0, if_valid}, 32'h1);
    chk("first_ifpc", if_pc, 32'h0);
    chk("first_inst", if_inst, 32'h0050_0093);
    cyc(0, 0, 32'h4, 0, 0, 32'h0);                 // accepted
    chk("next_addr", bus.imem_addr, 32'h4);

    // Stall in HOLD for five cycles
    cyc(0, 0, 32'h8, 1, 0, 32'h0);
    cyc(0, 1, 32'h8, 0, 1, 32'hDEAD_BEEF);
    repeat (5) cyc(0, 1, 32'h5555_5550, 1, 0, 32'h0);
    chk("stall_pc", pc, 32'h4);
    chk("stall_inst", if_inst, 32'hDEAD_BEEF);
    cyc(0, 0, 32'h8, 0, 0, 32'h0);

    // Flush while waiting; response arrives two cycles later and is dropped
    cyc(0, 0, 32'hC, 1, 0, 32'h0);
    cyc(1, 0, 32'h100, 0, 0, 32'h0);
    cyc(0, 0, 32'h104, 0, 0, 32'h0);
    cyc(0, 0, 32'h104, 0, 1, 32'h1234_5678);
    chk("flush_drop_valid", {31'h0, if_valid}, 32'h0);
    chk("flush_addr", bus.imem_addr, 32'h100);

    // Flush and stall together in HOLD: flush wins
    cyc(0, 0, 32'h104, 1, 0, 32'h0);
    cyc(0, 1, 32'h104, 0, 1, 32'hCAFE_0001);
    cyc(1, 1, 32'h200, 0, 0, 32'h0);
    chk("flush_hold_valid", {31'h0, if_valid}, 32'h0);
    chk("flush_hold_pc", pc, 32'h200);

    // Misaligned target
    cyc(0, 0, 32'h204, 1, 0, 32'h0);
    cyc(0, 1, 32'h204, 0, 1, 32'hCAFE_0002);
    cyc(0, 0, 32'h102, 0, 0, 32'h0);
    chk("mis_req", {31'h0, bus.imem_req}, MIS_EN ? 32'h0 : 32'h1);
    if (!MIS_EN) chk("mis_addr", bus.imem_addr, 32'h100);
    cyc(0, 1, 32'h104, 1, 0, 32'h0);
    cyc(0, 1, 32'h104, 0, 1, 32'hCAFE_0003);
    chk("mis_inst", if_inst, MIS_EN ? C_NOP : 32'hCAFE_0003);
    chk("mis_flag", {31'h0, if_misalign}, MIS_EN ? 32'h1 : 32'h0);
    cyc(0, 0, 32'h104, 0, 0, 32'h0);

    // Reset while waiting; stray response afterwards is ignored
    cyc(0, 0, 32'h108, 1, 0, 32'h0);
    do_reset(1);
    cyc(0, 0, 32'h4, 0, 1, 32'hBAD0_0001);         // IDLE -> FETCH
    cyc(0, 0, 32'h4, 0, 1, 32'hBAD0_0002);         // FETCH, not granted
    chk("rst_stray_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_pc", pc, RST_PC);

    // Randomized traffic
    mem_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      bit f, s, g, rv;
      logic [31:0] n, rd;
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
        continue;
      end
      f  = ($urandom_range(0, 7) == 0);
      s  = $urandom_range(0, 1) == 1;
      n  = f ? ($urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC))
             : m_pc + 32'h4;
      g  = m_req() && (mem_cnt == 0) && ($urandom_range(0, 2) != 0);
      rv = (mem_cnt == 1);
      rd = $urandom;
      cyc(f, s, n, g, rv, rd);
      if (rv) mem_cnt = 0;
      else if (mem_cnt > 1) mem_cnt--;
      if (g) mem_cnt = $urandom_range(1, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_if_fetch

`default_nettype wire
